// File: rtl/mat_mult_pkg.sv
// Shared types and helpers for the sequential N x N signed fixed-point matrix multiplier.
package mat_mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COMP = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Working width of sat_shift; comfortably wider than any accumulator in use.
    localparam int SAT_W = 128;

    typedef struct packed {
        logic signed [SAT_W-1:0] val;
        logic                    ovf;
    } sat_res_t;

    // Floor-shift right by frac, then clamp to the signed w-bit range.
    function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] acc,
                                           input int frac, input int w);
        sat_res_t                r;
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        s  = acc >>> frac;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        if (s > hi) begin
            r.val = hi;
            r.ovf = 1'b1;
        end else if (s < lo) begin
            r.val = lo;
            r.ovf = 1'b1;
        end else begin
            r.val = s;
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mat_mult_mac_lane.sv
// One output-column MAC lane: accumulator, init-from-previous-result mux and
// saturating writeback value for the element being finished this cycle.
module mat_mult_mac_lane
    import mat_mult_pkg::*;
#(
    parameter int W     = 27,
    parameter int FRAC  = 0,
    parameter int ACC_W = 56
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_i,
    input  logic                first_i,
    input  logic                mode_i,
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    input  logic signed [W-1:0] c_prev_i,
    output logic        [W-1:0] res_o,
    output logic                ovf_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] c_ext;
    logic signed [2*W-1:0]   prod;
    sat_res_t                sr;
    logic                    unused_hi;

    assign prod     = a_i * b_i;
    assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    // Previous result is re-expressed in accumulator scale before adding products.
    assign c_ext    = {{(ACC_W-W){c_prev_i[W-1]}}, c_prev_i} <<< FRAC;

    always_comb begin
        base = acc_q;
        if (first_i) begin
            base = mode_i ? c_ext : '0;
        end
    end

    assign acc_d     = base + prod_ext;
    assign sr        = sat_shift({{(SAT_W-ACC_W){acc_d[ACC_W-1]}}, acc_d}, FRAC, W);
    assign res_o     = sr.val[W-1:0];
    assign ovf_o     = sr.ovf;
    assign unused_hi = ^sr.val[SAT_W-1:W];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential N x N matrix multiplier: N MAC lanes produce one result row every N
// enabled cycles; whole matrices move through valid/ready handshakes.
module mat_mult_seq
    import mat_mult_pkg::*;
#(
    parameter int N    = 2,
    parameter int W    = 27,
    parameter int FRAC = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         mode,
    input  logic [N-1:0][N-1:0][W-1:0]   dataa,
    input  logic [N-1:0][N-1:0][W-1:0]   datab,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N-1:0][N-1:0][W-1:0]   result,
    output logic                         sat,
    output logic                         busy
);

    localparam int ACC_W = 2*W + $clog2(N) + 1;
    localparam int CW    = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N-1);

    state_e                       state_q;
    logic [CW-1:0]                i_q;
    logic [CW-1:0]                k_q;
    logic                         mode_q;
    logic                         sat_q;
    logic [N-1:0][N-1:0][W-1:0]   a_q;
    logic [N-1:0][N-1:0][W-1:0]   b_q;
    logic [N-1:0][N-1:0][W-1:0]   result_q;
    logic [W-1:0]                 lane_res [N];
    logic [N-1:0]                 lane_ovf;
    logic                         step;

    assign step      = en && (state_q == S_COMP);
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_COMP);
    assign result    = result_q;
    assign sat       = sat_q;

    for (genvar j = 0; j < N; j++) begin : g_lane
        mat_mult_mac_lane #(
            .W     (W),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .step_i   (step),
            .first_i  (k_q == '0),
            .mode_i   (mode_q),
            .a_i      (a_q[i_q][k_q]),
            .b_i      (b_q[k_q][j]),
            .c_prev_i (result_q[i_q][j]),
            .res_o    (lane_res[j]),
            .ovf_o    (lane_ovf[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            k_q      <= '0;
            mode_q   <= 1'b0;
            sat_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= dataa;
                        b_q     <= datab;
                        mode_q  <= mode;
                        sat_q   <= 1'b0;
                        i_q     <= '0;
                        k_q     <= '0;
                        state_q <= S_COMP;
                    end
                end
                S_COMP: begin
                    if (en) begin
                        if (k_q == LAST) begin
                            // Row i completes: lanes hold the final saturated values.
                            for (int j = 0; j < N; j++) begin
                                result_q[i_q][j] <= lane_res[j];
                            end
                            if (|lane_ovf) begin
                                sat_q <= 1'b1;
                            end
                            k_q <= '0;
                            if (i_q == LAST) begin
                                state_q <= S_DONE;
                            end else begin
                                i_q <= i_q + CW'(1);
                            end
                        end else begin
                            k_q <= k_q + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
